uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Downstream byte sink for the register-dump formatter. It accepts ASCII bytes through a single-cycle write strobe, buffers them in a small FIFO, and serializes them as 8N1 UART frames on uart_tx. It is the in-house replacement for the vendor UART master's transmit path: no register map and no TX-ready polling, only a full flag for back-pressure.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz.
BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, truncated; this is 234 at the defaults. Must be at least 2.
DEPTH, 16, FIFO entries. Must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write strobe, one byte per asserted cycle.
wr_data  in  8  byte to transmit.
full  out  1  FIFO full. A write while full is dropped.
overflow  out  1  sticky; set by a dropped write, cleared only by rst.
level  out  $clog2(DEPTH)+1  number of bytes stored, excluding the byte currently on the wire.
busy  out  1  high whenever the serializer is outside IDLE.
uart_tx  out  1  serial line; idles high.

Behaviour:
- Reset (rst high at a rising edge): uart_tx=1, busy=0, full=0, overflow=0, level=0, state=IDLE, FIFO pointers=0, bit and baud counters=0. Reset mid-frame aborts the frame immediately: uart_tx returns to 1 on the next edge and all stored bytes are discarded.
- Write: wr_en=1 and full=0 at edge E stores wr_data; level increments at E. wr_en=1 and full=1 stores nothing and sets overflow at E.
- full and level are registered. full = (level==DEPTH).
- Simultaneous write and pop with full=0: both occur and level is unchanged. Write while full is rejected even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. Bytes are transmitted in write order.
- State machine (IDLE, START, DATA, STOP), with baud counter bcnt and bit index bidx[2:0]:
  - IDLE: uart_tx=1. If level>0 at edge E: pop into shift register, go to START, uart_tx<=0, bcnt<=0.
  - A byte written into an empty idle block at edge E0 is popped at E0+1, so the start bit begins one cycle after the write.
  - START: holds uart_tx=0 for CLKS_PER_BIT cycles. Then go to DATA with bidx=0 and uart_tx<=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7, go to STOP with uart_tx<=1.
  - STOP: holds 1 for CLKS_PER_BIT cycles. On completion, if level>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- uart_tx is driven from a flop (glitch-free). busy=1 in START, DATA and STOP.
- Throughput: at the defaults the formatter's 16-byte message fits in DEPTH=16. The producer must honour full for longer bursts.

Test Plan:
(Bench parameters: CLK_HZ=400, BAUD=100, so CLKS_PER_BIT=4; DEPTH=4.)
1. Reset, then write 0x41 once at edge 10 -> uart_tx low on edges 11..14. Then bits 1,0,0,0,0,0,1,0 (LSB first), 4 cycles each. Then high for 4 cycles. busy falls at edge 51. level reads 1 at edge 10 and 0 at edge 11.
2. Write 0x52,0x65,0x67 on three consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between stop and start. Decoded bytes are "Reg" in order.
3. With the serializer busy, write 5 bytes back-to-back -> full asserts after the 4th stored write. The 5th write is dropped and overflow=1 stays set. Four correct frames follow, after the in-flight frame.
4. Hold full=1 while the STOP phase ends (pop) and wr_en=1 in the same cycle -> the write is dropped, level goes 4->3, overflow=1.
5. Assert rst during data bit 3 of 0x0D with 2 bytes queued -> the next edge gives uart_tx=1, level=0, busy=0, overflow=0. No further frames are sent.
6. Send "Regs[7]=0x00FF\r\n" at the defaults (CLKS_PER_BIT=234) -> the UART monitor decodes all 16 bytes exactly, with 2340 cycles per frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART serializer; producers write with a one-cycle
// strobe and back off on full, dropped writes latch a sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     uart_tx
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(CPB);

  generate
    if (CPB < 2) begin : g_bad_baud
      $error("CLK_HZ/BAUD must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   bcnt;
  logic [2:0]      bidx;
  logic [7:0]      shift;
  logic            push;
  logic            pop;
  logic            bit_done;
  logic [LW-1:0]   level_nx;

  // Handshake: a byte is accepted on any cycle with wr_en=1 and full=0; there
  // is no stall, so a write seen while full is discarded and flagged.
  assign push     = wr_en && !full;
  assign bit_done = (bcnt == CW'(CPB - 1));
  assign pop      = (level != '0) &&
                    ((state == IDLE) || ((state == STOP) && bit_done));

  always_comb begin
    level_nx = level;
    if (push && !pop)
      level_nx = level + 1'b1;
    else if (!push && pop)
      level_nx = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      level <= level_nx;
      full  <= (level_nx == LW'(DEPTH));
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

  // Serializer: a popped byte goes straight to START, so frames chain with
  // no idle gap when the FIFO still holds data at the end of STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      busy    <= 1'b0;
      bcnt    <= '0;
      bidx    <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rptr];
            state   <= START;
            busy    <= 1'b1;
            uart_tx <= 1'b0;
            bcnt    <= '0;
          end
        end
        START: begin
          if (bit_done) begin
            bcnt    <= '0;
            bidx    <= '0;
            state   <= DATA;
            uart_tx <= shift[0];
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bcnt <= '0;
            if (bidx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bidx    <= bidx + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bcnt <= '0;
            if (pop) begin
              shift   <= mem[rptr];
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small instance (4 clocks/bit, 4 entries)
// for cycle-exact framing and FIFO corner cases, plus a default-rate instance.
module tb_uart_tx_fifo;

  localparam int T_CPB = 4;
  localparam int B_CPB = 234;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic [2:0] level;
  logic       busy;
  logic       uart_tx;

  logic       wr_en_b;
  logic [7:0] wr_data_b;
  logic       full_b;
  logic       overflow_b;
  logic [4:0] level_b;
  logic       busy_b;
  logic       tx_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(400), .BAUD(100), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .level(level), .busy(busy), .uart_tx(uart_tx)
  );

  uart_tx_fifo u_big (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
    .overflow(overflow_b), .level(level_b), .busy(busy_b), .uart_tx(tx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic fbit(input logic [7:0] d, input int k);
    int i;
    i = k / T_CPB;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return d[i-1];
  endfunction

  // Checks frame samples first..last; leaves the bench at sample last+1.
  task automatic check_frame(input string tag, input logic [7:0] d, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      check($sformatf("%s k%0d", tag, k), {31'd0, uart_tx}, {31'd0, fbit(d, k)});
      tick(1);
    end
  endtask

  // Starts at the first start-bit sample, ends at the sample 10*B_CPB later.
  task automatic decode_big(output logic [7:0] b);
    b = '0;
    for (int k = 0; k < 10 * B_CPB; k++) begin
      if (k == B_CPB / 2)
        check("t6 start bit", {31'd0, tx_b}, 32'd0);
      if (k >= B_CPB && k < 9 * B_CPB && (k % B_CPB) == B_CPB / 2)
        b[(k - B_CPB) / B_CPB] = tx_b;
      if (k == 9 * B_CPB + B_CPB / 2 || k == 10 * B_CPB - 1)
        check($sformatf("t6 stop k%0d", k), {31'd0, tx_b}, 32'd1);
      tick(1);
    end
  endtask

  logic [7:0] b3 [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
  logic [2:0] b3_level [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic       b3_full [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       b3_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] b4 [4] = '{8'hB2, 8'hC3, 8'hD4, 8'hE5};
  logic [7:0] msg [16] = '{8'h52, 8'h65, 8'h67, 8'h73, 8'h5B, 8'h37, 8'h5D, 8'h3D,
                           8'h30, 8'h78, 8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_en_b = 1'b0; wr_data_b = '0;
    tick(3);
    check("rst tx", {31'd0, uart_tx}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst full", {31'd0, full}, 32'd0);
    check("rst ovf", {31'd0, overflow}, 32'd0);
    check("rst level", {29'd0, level}, 32'd0);
    rst = 1'b0;
    tick(6);

    // Test 1: single byte 0x41 written at edge 10
    wr_en = 1'b1; wr_data = 8'h41;
    tick(1);
    wr_en = 1'b0;
    check("t1 level@10", {29'd0, level}, 32'd1);
    check("t1 busy@10", {31'd0, busy}, 32'd0);
    check("t1 tx@10", {31'd0, uart_tx}, 32'd1);
    tick(1);
    check("t1 level@11", {29'd0, level}, 32'd0);
    check("t1 busy@11", {31'd0, busy}, 32'd1);
    check_frame("t1", 8'h41, 0, 38);
    check("t1 busy@50", {31'd0, busy}, 32'd1);
    check_frame("t1", 8'h41, 39, 39);
    check("t1 busy@51", {31'd0, busy}, 32'd0);
    check("t1 tx@51", {31'd0, uart_tx}, 32'd1);
    tick(3);

    // Test 2: "Reg" on consecutive cycles, contiguous frames
    wr_en = 1'b1; wr_data = 8'h52;
    tick(1);
    wr_data = 8'h65;
    tick(1);
    wr_data = 8'h67;
    tick(1);
    wr_en = 1'b0;
    check("t2 level", {29'd0, level}, 32'd2);
    check_frame("t2 R", 8'h52, 1, 39);
    check_frame("t2 e", 8'h65, 0, 39);
    check_frame("t2 g", 8'h67, 0, 39);
    check("t2 busy end", {31'd0, busy}, 32'd0);
    check("t2 level end", {29'd0, level}, 32'd0);
    tick(2);

    // Test 3: five writes behind an in-flight frame
    wr_en = 1'b1; wr_data = 8'h58;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    check("t3 busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = b3[i];
      tick(1);
      check($sformatf("t3 level w%0d", i), {29'd0, level}, {29'd0, b3_level[i]});
      check($sformatf("t3 full w%0d", i), {31'd0, full}, {31'd0, b3_full[i]});
      check($sformatf("t3 ovf w%0d", i), {31'd0, overflow}, {31'd0, b3_ovf[i]});
    end
    wr_en = 1'b0;
    check_frame("t3 X", 8'h58, 5, 39);
    for (int i = 0; i < 4; i++)
      check_frame($sformatf("t3 f%0d", i), b3[i], 0, 39);
    check("t3 busy end", {31'd0, busy}, 32'd0);
    check("t3 ovf sticky", {31'd0, overflow}, 32'd1);
    check("t3 level end", {29'd0, level}, 32'd0);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2 ovf", {31'd0, overflow}, 32'd0);
    tick(2);

    // Test 4: write while full on the STOP-end pop cycle
    wr_en = 1'b1; wr_data = 8'hA1;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = b4[i];
      tick(1);
    end
    wr_en = 1'b0;
    check("t4 full filled", {31'd0, full}, 32'd1);
    check_frame("t4 A1", 8'hA1, 4, 38);
    check("t4 full pre", {31'd0, full}, 32'd1);
    check("t4 level pre", {29'd0, level}, 32'd4);
    check("t4 ovf pre", {31'd0, overflow}, 32'd0);
    check("t4 tx stop", {31'd0, uart_tx}, 32'd1);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick(1);
    wr_en = 1'b0;
    check("t4 level post", {29'd0, level}, 32'd3);
    check("t4 full post", {31'd0, full}, 32'd0);
    check("t4 ovf post", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++)
      check_frame($sformatf("t4 f%0d", i), b4[i], 0, 39);
    check("t4 busy end", {31'd0, busy}, 32'd0);
    check("t4 level end", {29'd0, level}, 32'd0);

    // Test 5: reset during data bit 3 of 0x0D with two bytes queued
    check("t5 ovf before", {31'd0, overflow}, 32'd1);
    wr_en = 1'b1; wr_data = 8'h0D;
    tick(1);
    wr_data = 8'h11;
    tick(1);
    wr_data = 8'h22;
    tick(1);
    wr_en = 1'b0;
    check("t5 level", {29'd0, level}, 32'd2);
    check_frame("t5 0D", 8'h0D, 1, 17);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5 tx", {31'd0, uart_tx}, 32'd1);
    check("t5 level", {29'd0, level}, 32'd0);
    check("t5 busy", {31'd0, busy}, 32'd0);
    check("t5 ovf", {31'd0, overflow}, 32'd0);
    check("t5 full", {31'd0, full}, 32'd0);
    for (int i = 0; i < 60; i++) begin
      tick(1);
      check($sformatf("t5 quiet c%0d", i), {30'd0, busy, uart_tx}, 32'd1);
    end

    // Test 6: 16-byte message at the default rate
    for (int i = 0; i < 16; i++)
      exp_q.push_back(msg[i]);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          wr_en_b = 1'b1; wr_data_b = msg[i];
          tick(1);
        end
        wr_en_b = 1'b0;
      end
      begin
        int t;
        logic [7:0] b;
        t = 0;
        while (tx_b !== 1'b0 && t < 200) begin
          tick(1);
          t++;
        end
        check("t6 start seen", {31'd0, tx_b}, 32'd0);
        for (int f = 0; f < 16; f++) begin
          decode_big(b);
          check($sformatf("t6 byte%0d", f), {24'd0, b}, {24'd0, exp_q.pop_front()});
          if (f < 15)
            check($sformatf("t6 next start%0d", f), {31'd0, tx_b}, 32'd0);
        end
        check("t6 busy end", {31'd0, busy_b}, 32'd0);
        check("t6 ovf", {31'd0, overflow_b}, 32'd0);
        check("t6 tx idle", {31'd0, tx_b}, 32'd1);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
